// File: rtl/key_switch_io_pkg.sv
// key_switch_io_pkg
//   Shared constants and types for the KEY/SW memory-mapped input block:
//   register addresses, the bad-read pattern, register-select encoding and
//   the address decode helper.
package key_switch_io_pkg;

  localparam int NUM_KEYS = 4;
  localparam int NUM_SW   = 10;
  localparam int NUM_IN   = NUM_KEYS + NUM_SW;

  localparam logic [15:0] IO_KDATA = 16'hFFF0;
  localparam logic [15:0] IO_SDATA = 16'hFFF2;
  localparam logic [15:0] IO_KCTRL = 16'hFFF4;
  localparam logic [15:0] IO_SCTRL = 16'hFFF6;
  localparam logic [15:0] IO_BAD   = 16'hDEAD;

  // addr[2:1] selects one of the four registers inside the 8-byte window
  typedef enum logic [1:0] {
    REG_KDATA = 2'd0,
    REG_SDATA = 2'd1,
    REG_KCTRL = 2'd2,
    REG_SCTRL = 2'd3
  } reg_sel_e;

  function automatic logic io_hit(input logic [15:0] a);
    return a[15:3] == IO_KDATA[15:3];
  endfunction

endpackage

// File: rtl/key_switch_io_if.sv
// key_switch_io_if
//   M-stage data-memory bus as seen by the IO block.
//   master (CPU): drives addr/we/wdata, receives hit/rdata.
//   slave  (IO block): decodes addr, returns hit and combinational rdata.
interface key_switch_io_if #(parameter int DBITS = 16);
  logic [DBITS-1:0] addr;
  logic             we;
  logic [DBITS-1:0] wdata;
  logic             hit;
  logic [DBITS-1:0] rdata;

  modport master (output addr, we, wdata, input hit, rdata);
  modport slave  (input addr, we, wdata, output hit, rdata);
endinterface

// File: rtl/key_switch_io_debounce_bit.sv
// debounce_bit
//   One input bit: 2-flop synchroniser, tick-sampled agreement counter and
//   debounced level.
//   clk, reset : clock, synchronous active-high reset
//   tick       : one-cycle sample strobe from the shared prescaler
//   pin        : raw asynchronous input
//   db         : debounced level
//   chg        : high in the cycle db is about to take the synchronised value
//                (db still shows the old level during that cycle)
module debounce_bit #(
  parameter int DEB_TICKS = 4,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic pin,
  output logic db,
  output logic chg
);

  logic [1:0] sync;
  logic [3:0] cnt;
  logic       sync_v;

  assign sync_v = sync[1];
  assign chg    = tick && (sync_v != db) && (cnt == 4'(DEB_TICKS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= {2{RESET_VAL}};
      cnt  <= '0;
      db   <= RESET_VAL;
    end else begin
      sync <= {sync[0], pin};
      if (tick) begin
        if (sync_v == db) begin
          cnt <= '0;                 // agreement (or glitch over) drops any partial count
        end else if (chg) begin
          db  <= sync_v;
          cnt <= '0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/key_switch_io.sv
// key_switch_io
//   Memory-mapped KEY[3:0]/SW[9:0] input controller feeding the dmemout mux.
//   Debounces the pins, exposes levels (KDATA/SDATA) and sticky press/change
//   flags (KCTRL/SCTRL, write-1-to-clear).
//   clk, reset : clock, synchronous active-high reset
//   KEY        : raw active-low push-buttons
//   SW         : raw slide switches
//   bus        : M-stage bus (addr, we, wdata in; hit, rdata out)
module key_switch_io
  import key_switch_io_pkg::*;
#(
  parameter int DBITS       = 16,
  parameter int TICK_CYCLES = 50000,
  parameter int DEB_TICKS   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_KEYS-1:0]  KEY,
  input  logic [NUM_SW-1:0]    SW,
  key_switch_io_if.slave       bus
);

  localparam int PW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);

  // ---- sample tick ----
  logic [PW-1:0] presc;
  logic          tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      presc <= (presc == PRE_LAST) ? '0 : presc + PW'(1);
      tick  <= (presc == PRE_LAST);  // high in the cycle presc shows 0 again
    end
  end

  // ---- power-up arming: flags stay quiet until the first full debounce
  //      window after reset has passed, so the initial switch image is not
  //      reported as a change ----
  logic [4:0] arm_cnt;
  logic       armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else if (tick && !armed) begin
      arm_cnt <= arm_cnt + 5'd1;
      if (arm_cnt == 5'(DEB_TICKS)) armed <= 1'b1;
    end
  end

  // ---- debouncers: bits [3:0] keys, [13:4] switches ----
  logic [NUM_IN-1:0] raw, db, chg;
  assign raw = {SW, KEY};

  for (genvar g = 0; g < NUM_IN; g++) begin : g_deb
    debounce_bit #(
      .DEB_TICKS (DEB_TICKS),
      .RESET_VAL ((g < NUM_KEYS) ? 1'b1 : 1'b0)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .pin   (raw[g]),
      .db    (db[g]),
      .chg   (chg[g])
    );
  end

  logic [NUM_KEYS-1:0] keys_db, kpress;
  logic [NUM_SW-1:0]   sw_db, swchg;

  assign keys_db = db[NUM_KEYS-1:0];
  assign sw_db   = db[NUM_IN-1:NUM_KEYS];
  // chg fires while db still holds the old level: old 1 means a press
  assign kpress  = chg[NUM_KEYS-1:0] & keys_db & {NUM_KEYS{armed}};
  assign swchg   = chg[NUM_IN-1:NUM_KEYS] & {NUM_SW{armed}};

  // ---- decode ----
  reg_sel_e sel;
  logic     wr_k, wr_s;

  assign bus.hit = io_hit(bus.addr[15:0]);
  assign sel     = reg_sel_e'(bus.addr[2:1]);
  assign wr_k    = bus.hit && bus.we && (sel == REG_KCTRL);
  assign wr_s    = bus.hit && bus.we && (sel == REG_SCTRL);

  // ---- sticky flags: W1C, set wins over clear ----
  logic [NUM_KEYS-1:0] krdy, kovr, kclr;
  logic [NUM_SW-1:0]   schg, sclr;
  logic                sovr, soclr;

  assign kclr  = wr_k ? bus.wdata[3:0] : '0;
  assign sclr  = wr_s ? bus.wdata[9:0] : '0;
  assign soclr = wr_s && bus.wdata[15];

  always_ff @(posedge clk) begin
    if (reset) begin
      krdy <= '0;
      kovr <= '0;
      schg <= '0;
      sovr <= 1'b0;
    end else begin
      krdy <= (krdy & ~kclr) | kpress;
      kovr <= (kovr & ~bus.wdata[7:4] & ~{NUM_KEYS{~wr_k}} | kovr & {NUM_KEYS{~wr_k}})
              | (kpress & krdy);
      schg <= (schg & ~sclr) | swchg;
      sovr <= (sovr & ~soclr) | (|(swchg & schg));
    end
  end

  // ---- read mux ----
  always_comb begin
    bus.rdata = DBITS'(IO_BAD);
    if (bus.hit) begin
      case (sel)
        REG_KDATA: bus.rdata = DBITS'({12'b0, keys_db});
        REG_SDATA: bus.rdata = DBITS'({6'b0, sw_db});
        REG_KCTRL: bus.rdata = DBITS'({8'b0, kovr, krdy});
        REG_SCTRL: bus.rdata = DBITS'({sovr, 5'b0, schg});
        default:   bus.rdata = DBITS'(IO_BAD);
      endcase
    end
  end

  // byte-lane bit and unmapped write bits carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{bus.addr[0], bus.wdata[14:10]};

endmodule

// File: tb/tb_key_switch_io.sv
module tb_key_switch_io;
  import key_switch_io_pkg::*;

  localparam int TICK = 4;
  localparam int DEB  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic       rd_strb;

  key_switch_io_if #(.DBITS(16)) bus();

  key_switch_io #(.DBITS(16), .TICK_CYCLES(TICK), .DEB_TICKS(DEB)) dut (
    .clk   (clk),
    .reset (reset),
    .KEY   (KEY),
    .SW    (SW),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---- scoreboard ----
  typedef struct packed { logic hit; logic [15:0] data; } exp_t;
  exp_t  exp_q[$];
  string name_q[$];
  int    n_pass = 0;
  int    n_tot  = 0;
  exp_t  m_e;
  string m_nm;

  always @(negedge clk) begin
    if (rd_strb) begin
      n_tot++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_empty: read with no expected value queued");
      end else begin
        m_e  = exp_q.pop_front();
        m_nm = name_q.pop_front();
        if ({bus.hit, bus.rdata} === m_e) n_pass++;
        else $display("FAIL %s: got hit=%0b rdata=%h, expected hit=%0b rdata=%h",
                      m_nm, bus.hit, bus.rdata, m_e.hit, m_e.data);
      end
    end
  end

  // ---- stimulus helpers ----
  task automatic rd(input logic [15:0] a, input logic [15:0] d, input logic h, input string nm);
    @(posedge clk); #1;
    bus.addr = a; bus.we = 1'b0;
    exp_q.push_back({h, d});
    name_q.push_back(nm);
    rd_strb = 1'b1;
    @(negedge clk); #1 rd_strb = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    bus.addr = a; bus.wdata = d; bus.we = 1'b1;
    @(posedge clk); #1 bus.we = 1'b0;
  endtask

  // bounded wait for a register to reach a value; the following rd() is the check
  task automatic poll(input logic [15:0] a, input logic [15:0] d, input int max);
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      bus.addr = a; bus.we = 1'b0;
      @(negedge clk);
      if (bus.rdata == d) break;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen;
    reset = 1'b1; KEY = 4'hF; SW = 10'h000; rd_strb = 1'b0;
    bus.addr = 16'h0; bus.we = 1'b0; bus.wdata = 16'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state and decode
    rd(IO_KDATA, 16'h000F, 1'b1, "rst_kdata");
    rd(IO_SDATA, 16'h0000, 1'b1, "rst_sdata");
    rd(IO_KCTRL, 16'h0000, 1'b1, "rst_kctrl");
    rd(IO_SCTRL, 16'h0000, 1'b1, "rst_sctrl");
    rd(16'hFFF8, 16'hDEAD, 1'b0, "miss_fff8");

    // power-up switch image: level follows, no change flag
    @(posedge clk); #1 reset = 1'b1; SW = 10'h005;
    repeat (2) @(posedge clk); #1 reset = 1'b0;
    poll(IO_SDATA, 16'h0005, (DEB + 1) * TICK + 2);
    rd(IO_SDATA, 16'h0005, 1'b1, "pwrup_sdata");
    rd(IO_SCTRL, 16'h0000, 1'b1, "pwrup_no_schg");
    idle(30);

    // KEY[1] press
    @(posedge clk); #1 KEY = 4'hD;
    poll(IO_KCTRL, 16'h0002, 2 + DEB * TICK + 4);
    rd(IO_KDATA, 16'h000D, 1'b1, "k1_held_kdata");
    rd(IO_KCTRL, 16'h0002, 1'b1, "k1_press_kctrl");
    idle(14);
    #1 KEY = 4'hF;
    idle(24);
    rd(IO_KDATA, 16'h000F, 1'b1, "k1_release_kdata");
    rd(IO_KCTRL, 16'h0002, 1'b1, "k1_release_no_event");

    // KEY[2] glitch: low across exactly two sample ticks
    @(posedge clk); #1 KEY = 4'hB;
    repeat (2 * TICK) @(posedge clk);
    #1 KEY = 4'hF;
    idle(20);
    rd(IO_KDATA, 16'h000F, 1'b1, "glitch_kdata");
    rd(IO_KCTRL, 16'h0002, 1'b1, "glitch_kctrl");

    // second press while KRDY[1] still set -> overrun
    @(posedge clk); #1 KEY = 4'hD;
    poll(IO_KCTRL, 16'h0022, 2 + DEB * TICK + 4);
    rd(IO_KCTRL, 16'h0022, 1'b1, "k1_overrun");
    @(posedge clk); #1 KEY = 4'hF;
    idle(24);
    wr(IO_KCTRL, 16'h0022);
    rd(IO_KCTRL, 16'h0000, 1'b1, "kctrl_w1c");

    // clear written every cycle while a press event lands: set must win
    @(posedge clk); #1;
    KEY = 4'hD; bus.addr = IO_KCTRL; bus.wdata = 16'h0002; bus.we = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rdata[1]) begin seen = 1'b1; break; end
    end
    #1 bus.we = 1'b0;
    rd(IO_KCTRL, 16'h0002, 1'b1, "set_beats_clear");
    @(posedge clk); #1 KEY = 4'hF;
    idle(24);

    // data registers are read-only
    wr(IO_KDATA, 16'h0000);
    rd(IO_KDATA, 16'h000F, 1'b1, "kdata_ro");

    // switch change, then overrun on same bit
    @(posedge clk); #1 SW = 10'h004;
    poll(IO_SCTRL, 16'h0001, 2 + DEB * TICK + 4);
    rd(IO_SCTRL, 16'h0001, 1'b1, "sw0_chg");
    rd(IO_SDATA, 16'h0004, 1'b1, "sw0_sdata");
    @(posedge clk); #1 SW = 10'h005;
    poll(IO_SCTRL, 16'h8001, 2 + DEB * TICK + 4);
    rd(IO_SCTRL, 16'h8001, 1'b1, "sw0_ovr");

    // reset one cycle into a switch change
    @(posedge clk); #1 SW = 10'h3F5;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    rd(IO_SDATA, 16'h0000, 1'b1, "midrst_sdata");
    rd(IO_KDATA, 16'h000F, 1'b1, "midrst_kdata");
    rd(IO_KCTRL, 16'h0000, 1'b1, "midrst_kctrl");
    rd(IO_SCTRL, 16'h0000, 1'b1, "midrst_sctrl");
    idle(25);
    rd(IO_SDATA, 16'h03F5, 1'b1, "rearm_sdata");
    rd(IO_SCTRL, 16'h0000, 1'b1, "rearm_no_schg");

    // after re-arming, a change is flagged again and W1C clears it
    @(posedge clk); #1 SW = 10'h3F7;
    poll(IO_SCTRL, 16'h0002, 2 + DEB * TICK + 4);
    rd(IO_SCTRL, 16'h0002, 1'b1, "rearm_sw1_chg");
    wr(IO_SCTRL, 16'h0002);
    rd(IO_SCTRL, 16'h0000, 1'b1, "sctrl_w1c");

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
